// File: rtl/if_id_skid_register_if.sv
// IF/ID pipeline bus: fetch-side valid/ready offer plus decode-side stall,
// redirect flush and head-entry outputs.
interface if_id_skid_register_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int SIDE_WIDTH  = 4
);
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [PC_WIDTH-1:0]    IN_PC;
  logic [INSTR_WIDTH-1:0] IN_INSTRUCTION;
  logic [SIDE_WIDTH-1:0]  IN_SIDE;
  logic                   BUSYWAIT;
  logic                   FLUSH;
  logic                   OUT_VALID;
  logic [PC_WIDTH-1:0]    OUT_PC;
  logic [INSTR_WIDTH-1:0] OUT_INSTRUCTION;
  logic [SIDE_WIDTH-1:0]  OUT_SIDE;

  // Environment side: drives fetch offer, stall and flush.
  modport master (
    output IN_VALID, IN_PC, IN_INSTRUCTION, IN_SIDE, BUSYWAIT, FLUSH,
    input  IN_READY, OUT_VALID, OUT_PC, OUT_INSTRUCTION, OUT_SIDE
  );

  // Register side.
  modport slave (
    input  IN_VALID, IN_PC, IN_INSTRUCTION, IN_SIDE, BUSYWAIT, FLUSH,
    output IN_READY, OUT_VALID, OUT_PC, OUT_INSTRUCTION, OUT_SIDE
  );
endinterface

// File: rtl/if_id_skid_register.sv
// IF/ID register with a 2-entry valid/ready skid buffer, synchronous
// redirect flush and registered NOP bubble on the outputs.
// Optional macro IF_ID_PERF_COUNT_EN adds saturating STALL_COUNT and
// FLUSH_DROP_COUNT outputs.
module if_id_skid_register #(
  parameter int                      PC_WIDTH    = 32,
  parameter int                      INSTR_WIDTH = 32,
  parameter int                      SIDE_WIDTH  = 4,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef IF_ID_PERF_COUNT_EN
  output logic [31:0] STALL_COUNT,
  output logic [31:0] FLUSH_DROP_COUNT,
`endif
  if_id_skid_register_if.slave bus
);

  localparam logic [1:0] EMPTY = 2'd0;  // main invalid
  localparam logic [1:0] FULL  = 2'd1;  // main valid, skid invalid
  localparam logic [1:0] SKID  = 2'd2;  // both valid

  logic [1:0]             state;
  logic [PC_WIDTH-1:0]    main_pc,    skid_pc;
  logic [INSTR_WIDTH-1:0] main_instr, skid_instr;
  logic [SIDE_WIDTH-1:0]  main_side,  skid_side;
  logic                   accept, take;

  // Ready depends only on registered state, so no BUSYWAIT-to-ready path.
  assign bus.IN_READY        = (state != SKID);
  assign bus.OUT_VALID       = (state != EMPTY);
  assign bus.OUT_PC          = main_pc;
  assign bus.OUT_INSTRUCTION = main_instr;
  assign bus.OUT_SIDE        = main_side;

  assign accept = bus.IN_VALID & bus.IN_READY;
  assign take   = bus.OUT_VALID & ~bus.BUSYWAIT;

  // State and payload update; main is reloaded with the bubble whenever it
  // goes invalid so outputs never depend on a mux of the valid bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      main_side  <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_side  <= '0;
    end else if (bus.FLUSH) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      main_side  <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state      <= FULL;
          main_pc    <= bus.IN_PC;
          main_instr <= bus.IN_INSTRUCTION;
          main_side  <= bus.IN_SIDE;
        end
        FULL: begin
          if (accept && take) begin
            main_pc    <= bus.IN_PC;
            main_instr <= bus.IN_INSTRUCTION;
            main_side  <= bus.IN_SIDE;
          end else if (accept) begin
            state      <= SKID;
            skid_pc    <= bus.IN_PC;
            skid_instr <= bus.IN_INSTRUCTION;
            skid_side  <= bus.IN_SIDE;
          end else if (take) begin
            state      <= EMPTY;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
            main_side  <= '0;
          end
        end
        SKID: if (take) begin
          state      <= FULL;
          main_pc    <= skid_pc;
          main_instr <= skid_instr;
          main_side  <= skid_side;
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef IF_ID_PERF_COUNT_EN
  logic [1:0]  drop_n;
  logic [32:0] drop_sum;

  // Entries lost to a flush: one per held valid entry.
  always_comb begin
    drop_n = 2'd0;
    if (state == FULL) drop_n = 2'd1;
    if (state == SKID) drop_n = 2'd2;
    drop_sum = {1'b0, FLUSH_DROP_COUNT} + {31'd0, drop_n};
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_COUNT      <= '0;
      FLUSH_DROP_COUNT <= '0;
    end else begin
      if (bus.OUT_VALID && bus.BUSYWAIT && (STALL_COUNT != 32'hFFFFFFFF))
        STALL_COUNT <= STALL_COUNT + 32'd1;
      if (bus.FLUSH)
        FLUSH_DROP_COUNT <= drop_sum[32] ? 32'hFFFFFFFF : drop_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// Directed bench for if_id_skid_register: reset bubble, streaming, skid
// fill/drain, flush, flush/offer collision, mid-operation reset.
module tb_if_id_skid_register;
  logic CLK = 1'b0;
  logic RESET;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  if_id_skid_register_if bus ();

`ifdef IF_ID_PERF_COUNT_EN
  logic [31:0] STALL_COUNT, FLUSH_DROP_COUNT;
`endif

  if_id_skid_register dut (
    .CLK              (CLK),
    .RESET            (RESET),
`ifdef IF_ID_PERF_COUNT_EN
    .STALL_COUNT      (STALL_COUNT),
    .FLUSH_DROP_COUNT (FLUSH_DROP_COUNT),
`endif
    .bus              (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] pc);
    bus.IN_VALID       = 1'b1;
    bus.IN_PC          = pc;
    bus.IN_INSTRUCTION = 32'hA000_0000 | pc;
    bus.IN_SIDE        = pc[5:2];
  endtask

  task automatic idle();
    bus.IN_VALID       = 1'b0;
    bus.IN_PC          = 'x;
    bus.IN_INSTRUCTION = 'x;
    bus.IN_SIDE        = 'x;
  endtask

  task automatic bubble(input string tag);
    chk({tag, "_valid"}, 64'(bus.OUT_VALID), 64'd0);
    chk({tag, "_pc"},    64'(bus.OUT_PC), 64'd0);
    chk({tag, "_instr"}, 64'(bus.OUT_INSTRUCTION), 64'(NOP));
    chk({tag, "_side"},  64'(bus.OUT_SIDE), 64'd0);
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(bus.OUT_VALID), 64'd1);
    chk({tag, "_pc"},    64'(bus.OUT_PC), 64'(pc));
    chk({tag, "_instr"}, 64'(bus.OUT_INSTRUCTION), 64'(32'hA000_0000 | pc));
  endtask

  initial begin
    RESET = 1'b1;
    bus.BUSYWAIT = 1'b0;
    bus.FLUSH    = 1'b0;
    idle();
    #3;
    bubble("reset");
    chk("reset_ready", 64'(bus.IN_READY), 64'd1);
    step();
    RESET = 1'b0;

    // Streaming at full rate.
    offer(32'h00); step(); head("stream0", 32'h00); chk("stream0_ready", 64'(bus.IN_READY), 64'd1);
    offer(32'h04); step(); head("stream1", 32'h04); chk("stream1_ready", 64'(bus.IN_READY), 64'd1);
    offer(32'h08); step(); head("stream2", 32'h08); chk("stream2_side", 64'(bus.OUT_SIDE), 64'd2);
    idle();        step(); bubble("drain");

    // Skid fill under stall, then drain in order.
    bus.BUSYWAIT = 1'b1;
    offer(32'h10); step(); head("fill0", 32'h10); chk("fill0_ready", 64'(bus.IN_READY), 64'd1);
    offer(32'h14); step(); head("fill1", 32'h10); chk("fill1_ready", 64'(bus.IN_READY), 64'd0);
    offer(32'h99); step(); head("hold", 32'h10);  chk("hold_ready", 64'(bus.IN_READY), 64'd0);
    idle(); bus.BUSYWAIT = 1'b0;
    step(); head("skid_out", 32'h14); chk("skid_out_ready", 64'(bus.IN_READY), 64'd1);
    step(); bubble("skid_empty");

    // Flush from SKID.
    bus.BUSYWAIT = 1'b1;
    offer(32'h20); step();
    offer(32'h24); step(); head("pre_flush", 32'h20);
    idle(); bus.FLUSH = 1'b1;
    step(); bubble("flush"); chk("flush_ready", 64'(bus.IN_READY), 64'd1);
`ifdef IF_ID_PERF_COUNT_EN
    chk("flush_drop2", 64'(FLUSH_DROP_COUNT), 64'd2);
`endif
    bus.FLUSH = 1'b0; bus.BUSYWAIT = 1'b0;
    offer(32'h80); step(); head("post_flush", 32'h80);
    idle();        step(); bubble("no_0x24");

    // Flush colliding with an offer from FULL.
    offer(32'h30); step(); head("coll_full", 32'h30);
    bus.BUSYWAIT = 1'b1; bus.FLUSH = 1'b1; offer(32'h40);
    step(); bubble("coll_flush");
    bus.FLUSH = 1'b0; bus.BUSYWAIT = 1'b0; idle();
    step(); bubble("no_0x40");
`ifdef IF_ID_PERF_COUNT_EN
    chk("flush_drop3", 64'(FLUSH_DROP_COUNT), 64'd3);
`endif

    // Asynchronous reset with two entries held.
    bus.BUSYWAIT = 1'b1;
    offer(32'h50); step();
    offer(32'h54); step(); chk("pre_rst_ready", 64'(bus.IN_READY), 64'd0);
    idle();
    #2 RESET = 1'b1;
    #1 bubble("async_rst"); chk("async_rst_ready", 64'(bus.IN_READY), 64'd1);
    step();
    RESET = 1'b0; bus.BUSYWAIT = 1'b0;
    step(); bubble("rst_dropped");

    // First accept right after reset, then a 5-cycle stall.
    bus.BUSYWAIT = 1'b1;
    offer(32'h60); step(); head("stall_head", 32'h60);
    idle();
    for (int i = 0; i < 5; i++) step();
    head("stall_hold", 32'h60);
`ifdef IF_ID_PERF_COUNT_EN
    chk("stall_count5", 64'(STALL_COUNT), 64'd5);
    chk("drop_cleared", 64'(FLUSH_DROP_COUNT), 64'd0);
`endif
    bus.BUSYWAIT = 1'b0;
    step(); bubble("stall_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
